// File: rtl/csr_file_m_if.sv
// csr_file_m_if: bus bundle for the machine-mode CSR file.
//   master : pipeline/CLINT side. It drives read/write/trap/mret/instret/timer
//            and receives the read data and status outputs.
//   slave  : the CSR file itself.
//   Signals keep the CSR file's port names:
//     read port   : csr_raddr_i -> csr_rdata_o, csr_illegal_o
//     write port  : csr_wen_i, csr_waddr_i, csr_wdata_i, csr_op_i
//     trap / mret : trap_i, trap_pc_i, trap_cause_i, mret_i
//     events      : instret_i, timer_irq_i
//     status      : mstatus_o, mepc_o, trap_vec_o, irq_pending_o
`timescale 1ns/1ps
interface csr_file_m_if #(
    parameter int XLEN = 64
);
    logic [11:0]     csr_raddr_i;
    logic [XLEN-1:0] csr_rdata_o;
    logic            csr_illegal_o;
    logic            csr_wen_i;
    logic [11:0]     csr_waddr_i;
    logic [XLEN-1:0] csr_wdata_i;
    logic [1:0]      csr_op_i;
    logic            trap_i;
    logic [XLEN-1:0] trap_pc_i;
    logic [XLEN-1:0] trap_cause_i;
    logic            mret_i;
    logic            instret_i;
    logic            timer_irq_i;
    logic [XLEN-1:0] mstatus_o;
    logic [XLEN-1:0] mepc_o;
    logic [XLEN-1:0] trap_vec_o;
    logic            irq_pending_o;

    modport master (
        output csr_raddr_i, csr_wen_i, csr_waddr_i, csr_wdata_i, csr_op_i,
               trap_i, trap_pc_i, trap_cause_i, mret_i, instret_i, timer_irq_i,
        input  csr_rdata_o, csr_illegal_o, mstatus_o, mepc_o, trap_vec_o,
               irq_pending_o
    );

    modport slave (
        input  csr_raddr_i, csr_wen_i, csr_waddr_i, csr_wdata_i, csr_op_i,
               trap_i, trap_pc_i, trap_cause_i, mret_i, instret_i, timer_irq_i,
        output csr_rdata_o, csr_illegal_o, mstatus_o, mepc_o, trap_vec_o,
               irq_pending_o
    );
endinterface

// File: rtl/csr_file_m.sv
// csr_file_m: machine-mode CSR file (mstatus, mie, mtvec, mscratch, mepc,
// mcause, mip, mcycle, minstret).
//   clk  : core clock
//   rst  : asynchronous reset, active low
//   bus  : csr_file_m_if.slave. It carries the combinational read port, the
//          software write port (RW/RS/RC), the trap/mret inputs, the instret
//          and timer inputs, and the mstatus/mepc/trap vector/irq outputs.
// Update priority each cycle is trap > mret > software write. A trap or mret
// suppresses the whole software write, so EX must replay it. The counters tick
// independently of that priority.
`timescale 1ns/1ps
module csr_file_m #(
    parameter int          XLEN         = 64,
    parameter logic [63:0] MTVEC_RESET  = 64'h8000_0000,
    parameter bit          HAS_COUNTERS = 1'b1
) (
    input logic         clk,
    input logic         rst,
    csr_file_m_if.slave bus
);
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;

    logic            r_mie_b;     // mstatus.MIE
    logic            r_mpie_b;    // mstatus.MPIE
    logic            r_mtie;      // mie.MTIE
    logic            r_mtip;      // mip.MTIP (timer level, one cycle late)
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mcycle;
    logic [XLEN-1:0] r_minstret;

    logic [XLEN-1:0] w_mstatus;
    logic [XLEN-1:0] w_mie;
    logic [XLEN-1:0] w_mip;
    logic [XLEN-1:0] w_old;
    logic [XLEN-1:0] w_new;
    logic            w_sw_we;
    logic [XLEN-1:0] w_vec_base;
    logic            w_unused;

    // Bit XLEN-2 of the cause shifts out of the vectored offset. It is unused on purpose.
    assign w_unused = bus.trap_cause_i[XLEN-2];

    always_comb begin
        w_mstatus        = '0;
        w_mstatus[12:11] = 2'b11;
        w_mstatus[7]     = r_mpie_b;
        w_mstatus[3]     = r_mie_b;
        w_mie            = '0;
        w_mie[7]         = r_mtie;
        w_mip            = '0;
        w_mip[7]         = r_mtip;
    end

    function automatic logic csr_legal(input logic [11:0] a);
        case (a)
            A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE,
            A_MIP, A_MCYCLE, A_MINSTRET: csr_legal = 1'b1;
            default:                     csr_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] csr_mux(
        input logic [11:0]     a,
        input logic [XLEN-1:0] mstatus, mie, mtvec, mscratch, mepc,
        input logic [XLEN-1:0] mcause, mip, mcycle, minstret
    );
        case (a)
            A_MSTATUS:  csr_mux = mstatus;
            A_MIE:      csr_mux = mie;
            A_MTVEC:    csr_mux = mtvec;
            A_MSCRATCH: csr_mux = mscratch;
            A_MEPC:     csr_mux = mepc;
            A_MCAUSE:   csr_mux = mcause;
            A_MIP:      csr_mux = mip;
            A_MCYCLE:   csr_mux = mcycle;
            A_MINSTRET: csr_mux = minstret;
            default:    csr_mux = '0;
        endcase
    endfunction

    // The read port returns registered state only. A write to the read address
    // in the same cycle becomes visible one cycle later.
    assign bus.csr_rdata_o   = csr_mux(bus.csr_raddr_i, w_mstatus, w_mie, r_mtvec,
                                       r_mscratch, r_mepc, r_mcause, w_mip,
                                       r_mcycle, r_minstret);
    assign bus.csr_illegal_o = ~csr_legal(bus.csr_raddr_i);

    // Old value at the write address feeds the set/clear operations.
    assign w_old = csr_mux(bus.csr_waddr_i, w_mstatus, w_mie, r_mtvec,
                           r_mscratch, r_mepc, r_mcause, w_mip,
                           r_mcycle, r_minstret);

    always_comb begin
        case (bus.csr_op_i)
            2'b00:   w_new = bus.csr_wdata_i;
            2'b01:   w_new = w_old | bus.csr_wdata_i;
            2'b10:   w_new = w_old & ~bus.csr_wdata_i;
            default: w_new = w_old;
        endcase
    end

    assign w_sw_we = bus.csr_wen_i && (bus.csr_op_i != 2'b11) && !bus.trap_i &&
                     !bus.mret_i && csr_legal(bus.csr_waddr_i);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mie_b    <= 1'b0;
            r_mpie_b   <= 1'b0;
            r_mtie     <= 1'b0;
            r_mtip     <= 1'b0;
            r_mtvec    <= MTVEC_RESET[XLEN-1:0];
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else begin
            r_mtip <= bus.timer_irq_i;

            // A software write to a counter replaces that cycle's increment.
            if (HAS_COUNTERS) begin
                if (w_sw_we && bus.csr_waddr_i == A_MCYCLE)
                    r_mcycle <= w_new;
                else
                    r_mcycle <= r_mcycle + 1'b1;
                if (w_sw_we && bus.csr_waddr_i == A_MINSTRET)
                    r_minstret <= w_new;
                else if (bus.instret_i)
                    r_minstret <= r_minstret + 1'b1;
            end else begin
                r_mcycle   <= '0;
                r_minstret <= '0;
            end

            if (bus.trap_i) begin
                r_mepc   <= {bus.trap_pc_i[XLEN-1:1], 1'b0};
                r_mcause <= bus.trap_cause_i;
                r_mpie_b <= r_mie_b;
                r_mie_b  <= 1'b0;
            end else if (bus.mret_i) begin
                r_mie_b  <= r_mpie_b;
                r_mpie_b <= 1'b1;
            end else if (w_sw_we) begin
                case (bus.csr_waddr_i)
                    A_MSTATUS: begin
                        r_mie_b  <= w_new[3];
                        r_mpie_b <= w_new[7];
                    end
                    A_MIE:      r_mtie     <= w_new[7];
                    // Reserved modes 2/3 collapse to direct.
                    A_MTVEC:    r_mtvec    <= {w_new[XLEN-1:2],
                                               (w_new[1:0] == 2'b01) ? 2'b01 : 2'b00};
                    A_MSCRATCH: r_mscratch <= w_new;
                    A_MEPC:     r_mepc     <= {w_new[XLEN-1:1], 1'b0};
                    A_MCAUSE:   r_mcause   <= w_new;
                    default:    ;
                endcase
            end
        end
    end

    // Vectored interrupts jump to base + 4*cause. Everything else goes to base.
    assign w_vec_base     = {r_mtvec[XLEN-1:2], 2'b00};
    assign bus.trap_vec_o = (r_mtvec[1:0] == 2'b01 && bus.trap_cause_i[XLEN-1])
                          ? w_vec_base + {bus.trap_cause_i[XLEN-3:0], 2'b00}
                          : w_vec_base;

    assign bus.mstatus_o     = w_mstatus;
    assign bus.mepc_o        = r_mepc;
    assign bus.irq_pending_o = r_mie_b & r_mtie & r_mtip;
endmodule

// File: tb/tb_csr_file_m.sv
// tb_csr_file_m: directed bench for csr_file_m (XLEN=64). Inputs change 1ns
// after the rising edge, and outputs are checked before the next edge.
`timescale 1ns/1ps
module tb_csr_file_m;
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [63:0] ONES       = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    csr_file_m_if #(.XLEN(64)) bus ();

    csr_file_m #(.XLEN(64), .MTVEC_RESET(64'h8000_0000), .HAS_COUNTERS(1'b1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] a);
        bus.csr_raddr_i = a;
        #1;
    endtask

    task automatic sw(input logic [11:0] a, input logic [63:0] d, input logic [1:0] op);
        bus.csr_waddr_i = a;
        bus.csr_wdata_i = d;
        bus.csr_op_i    = op;
        bus.csr_wen_i   = 1'b1;
        step();
        bus.csr_wen_i   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        if (bus.mstatus_o !== 64'h1800) begin $display("FAIL rst_mstatus got=%h exp=%h", bus.mstatus_o, 64'h1800); failures++; end checks++;
        if (bus.mepc_o !== 64'h0) begin $display("FAIL rst_mepc got=%h exp=%h", bus.mepc_o, 64'h0); failures++; end checks++;
        rd(A_MTVEC);
        if (bus.csr_rdata_o !== 64'h8000_0000) begin $display("FAIL rst_mtvec got=%h exp=%h", bus.csr_rdata_o, 64'h8000_0000); failures++; end checks++;
        if (bus.trap_vec_o !== 64'h8000_0000) begin $display("FAIL rst_trapvec got=%h exp=%h", bus.trap_vec_o, 64'h8000_0000); failures++; end checks++;
        rd(A_MCYCLE);
        if (bus.csr_rdata_o !== 64'h0) begin $display("FAIL rst_mcycle got=%h exp=%h", bus.csr_rdata_o, 64'h0); failures++; end checks++;
        if (bus.irq_pending_o !== 1'b0) begin $display("FAIL rst_irq got=%b exp=0", bus.irq_pending_o); failures++; end checks++;
        rst = 1'b1;
        step();
    endtask

    task automatic test_ops();
        sw(A_MSCRATCH, 64'hF0, 2'b00);
        rd(A_MSCRATCH);
        if (bus.csr_rdata_o !== 64'hF0) begin $display("FAIL op_rw got=%h exp=%h", bus.csr_rdata_o, 64'hF0); failures++; end checks++;
        // RS while reading the same CSR: the old value is seen until the edge.
        bus.csr_waddr_i = A_MSCRATCH; bus.csr_wdata_i = 64'h0F; bus.csr_op_i = 2'b01; bus.csr_wen_i = 1'b1;
        #1;
        if (bus.csr_rdata_o !== 64'hF0) begin $display("FAIL op_nobypass got=%h exp=%h", bus.csr_rdata_o, 64'hF0); failures++; end checks++;
        step();
        bus.csr_wen_i = 1'b0;
        rd(A_MSCRATCH);
        if (bus.csr_rdata_o !== 64'hFF) begin $display("FAIL op_rs got=%h exp=%h", bus.csr_rdata_o, 64'hFF); failures++; end checks++;
        sw(A_MSCRATCH, 64'h3C, 2'b10);
        rd(A_MSCRATCH);
        if (bus.csr_rdata_o !== 64'hC3) begin $display("FAIL op_rc got=%h exp=%h", bus.csr_rdata_o, 64'hC3); failures++; end checks++;
        sw(A_MSTATUS, ONES, 2'b00);
        rd(A_MSTATUS);
        if (bus.mstatus_o !== 64'h1888) begin $display("FAIL mstatus_mask got=%h exp=%h", bus.mstatus_o, 64'h1888); failures++; end checks++;
        if (bus.csr_rdata_o !== 64'h1888) begin $display("FAIL mstatus_read got=%h exp=%h", bus.csr_rdata_o, 64'h1888); failures++; end checks++;
        sw(A_MEPC, 64'hFFFF, 2'b00);
        if (bus.mepc_o !== 64'hFFFE) begin $display("FAIL mepc_bit0 got=%h exp=%h", bus.mepc_o, 64'hFFFE); failures++; end checks++;
        sw(A_MTVEC, 64'h8000_0002, 2'b00);
        rd(A_MTVEC);
        if (bus.csr_rdata_o !== 64'h8000_0000) begin $display("FAIL mtvec_mode2 got=%h exp=%h", bus.csr_rdata_o, 64'h8000_0000); failures++; end checks++;
        sw(A_MCAUSE, 64'h8000_0000_0000_0003, 2'b00);
        rd(A_MCAUSE);
        if (bus.csr_rdata_o !== 64'h8000_0000_0000_0003) begin $display("FAIL mcause_rw got=%h exp=%h", bus.csr_rdata_o, 64'h8000_0000_0000_0003); failures++; end checks++;
    endtask

    task automatic test_trap();
        sw(A_MSTATUS, 64'h8, 2'b00);
        if (bus.mstatus_o !== 64'h1808) begin $display("FAIL trap_setup got=%h exp=%h", bus.mstatus_o, 64'h1808); failures++; end checks++;
        sw(A_MTVEC, 64'h8000_0001, 2'b00);
        bus.trap_pc_i    = 64'h8000_0105;
        bus.trap_cause_i = 64'h0000_0000_0000_0007;
        #1;
        if (bus.trap_vec_o !== 64'h8000_0000) begin $display("FAIL vec_sync got=%h exp=%h", bus.trap_vec_o, 64'h8000_0000); failures++; end checks++;
        bus.trap_cause_i = 64'h8000_0000_0000_0007;
        #1;
        if (bus.trap_vec_o !== 64'h8000_001C) begin $display("FAIL vec_irq got=%h exp=%h", bus.trap_vec_o, 64'h8000_001C); failures++; end checks++;
        bus.trap_i = 1'b1;
        step();
        bus.trap_i = 1'b0;
        if (bus.mepc_o !== 64'h8000_0104) begin $display("FAIL trap_mepc got=%h exp=%h", bus.mepc_o, 64'h8000_0104); failures++; end checks++;
        if (bus.mstatus_o !== 64'h1880) begin $display("FAIL trap_mstatus got=%h exp=%h", bus.mstatus_o, 64'h1880); failures++; end checks++;
        rd(A_MCAUSE);
        if (bus.csr_rdata_o !== 64'h8000_0000_0000_0007) begin $display("FAIL trap_mcause got=%h exp=%h", bus.csr_rdata_o, 64'h8000_0000_0000_0007); failures++; end checks++;
        bus.mret_i = 1'b1;
        step();
        bus.mret_i = 1'b0;
        if (bus.mstatus_o !== 64'h1888) begin $display("FAIL mret_mstatus got=%h exp=%h", bus.mstatus_o, 64'h1888); failures++; end checks++;
    endtask

    task automatic test_collision();
        // trap + mret + write: only the trap takes effect.
        bus.trap_i = 1'b1; bus.mret_i = 1'b1;
        bus.trap_pc_i = 64'h200; bus.trap_cause_i = 64'hB;
        sw(A_MSCRATCH, 64'h1234, 2'b00);
        bus.trap_i = 1'b0; bus.mret_i = 1'b0;
        rd(A_MSCRATCH);
        if (bus.csr_rdata_o !== 64'hC3) begin $display("FAIL coll_mscratch got=%h exp=%h", bus.csr_rdata_o, 64'hC3); failures++; end checks++;
        if (bus.mstatus_o !== 64'h1880) begin $display("FAIL coll_mstatus got=%h exp=%h", bus.mstatus_o, 64'h1880); failures++; end checks++;
        if (bus.mepc_o !== 64'h200) begin $display("FAIL coll_mepc got=%h exp=%h", bus.mepc_o, 64'h200); failures++; end checks++;
        rd(A_MCAUSE);
        if (bus.csr_rdata_o !== 64'hB) begin $display("FAIL coll_mcause got=%h exp=%h", bus.csr_rdata_o, 64'hB); failures++; end checks++;
        // mret alone still blocks an unrelated write.
        bus.mret_i = 1'b1;
        sw(A_MSCRATCH, 64'h5678, 2'b00);
        bus.mret_i = 1'b0;
        rd(A_MSCRATCH);
        if (bus.csr_rdata_o !== 64'hC3) begin $display("FAIL mret_blocks got=%h exp=%h", bus.csr_rdata_o, 64'hC3); failures++; end checks++;
        if (bus.mstatus_o !== 64'h1888) begin $display("FAIL mret2_mstatus got=%h exp=%h", bus.mstatus_o, 64'h1888); failures++; end checks++;
    endtask

    task automatic test_irq();
        sw(A_MIE, ONES, 2'b00);
        rd(A_MIE);
        if (bus.csr_rdata_o !== 64'h80) begin $display("FAIL mie_mask got=%h exp=%h", bus.csr_rdata_o, 64'h80); failures++; end checks++;
        bus.timer_irq_i = 1'b1;
        #1;
        if (bus.irq_pending_o !== 1'b0) begin $display("FAIL irq_early got=%b exp=0", bus.irq_pending_o); failures++; end checks++;
        step();
        if (bus.irq_pending_o !== 1'b1) begin $display("FAIL irq_rise got=%b exp=1", bus.irq_pending_o); failures++; end checks++;
        rd(A_MIP);
        if (bus.csr_rdata_o !== 64'h80) begin $display("FAIL mip_mtip got=%h exp=%h", bus.csr_rdata_o, 64'h80); failures++; end checks++;
        sw(A_MIP, 64'h0, 2'b00);
        rd(A_MIP);
        if (bus.csr_rdata_o !== 64'h80) begin $display("FAIL mip_ro got=%h exp=%h", bus.csr_rdata_o, 64'h80); failures++; end checks++;
        sw(A_MSTATUS, 64'h8, 2'b10);
        if (bus.irq_pending_o !== 1'b0) begin $display("FAIL irq_fall got=%b exp=0", bus.irq_pending_o); failures++; end checks++;
        bus.timer_irq_i = 1'b0;
        step();
        rd(A_MIP);
        if (bus.csr_rdata_o !== 64'h0) begin $display("FAIL mip_clear got=%h exp=%h", bus.csr_rdata_o, 64'h0); failures++; end checks++;
    endtask

    task automatic test_illegal();
        rd(12'h7C0);
        if (bus.csr_rdata_o !== 64'h0) begin $display("FAIL ill_rdata got=%h exp=%h", bus.csr_rdata_o, 64'h0); failures++; end checks++;
        if (bus.csr_illegal_o !== 1'b1) begin $display("FAIL ill_flag got=%b exp=1", bus.csr_illegal_o); failures++; end checks++;
        rd(A_MINSTRET);
        if (bus.csr_illegal_o !== 1'b0) begin $display("FAIL legal_flag got=%b exp=0", bus.csr_illegal_o); failures++; end checks++;
        sw(12'h7C0, ONES, 2'b00);
        rd(A_MSCRATCH);
        if (bus.csr_rdata_o !== 64'hC3) begin $display("FAIL ill_write got=%h exp=%h", bus.csr_rdata_o, 64'hC3); failures++; end checks++;
        if (bus.mstatus_o !== 64'h1880) begin $display("FAIL ill_mstatus got=%h exp=%h", bus.mstatus_o, 64'h1880); failures++; end checks++;
        sw(A_MSCRATCH, 64'h55, 2'b11);
        rd(A_MSCRATCH);
        if (bus.csr_rdata_o !== 64'hC3) begin $display("FAIL op_reserved got=%h exp=%h", bus.csr_rdata_o, 64'hC3); failures++; end checks++;
    endtask

    task automatic test_counters();
        sw(A_MCYCLE, ONES, 2'b00);
        rd(A_MCYCLE);
        if (bus.csr_rdata_o !== ONES) begin $display("FAIL mcycle_write got=%h exp=%h", bus.csr_rdata_o, ONES); failures++; end checks++;
        step();
        if (bus.csr_rdata_o !== 64'h0) begin $display("FAIL mcycle_wrap got=%h exp=%h", bus.csr_rdata_o, 64'h0); failures++; end checks++;
        step();
        if (bus.csr_rdata_o !== 64'h1) begin $display("FAIL mcycle_inc got=%h exp=%h", bus.csr_rdata_o, 64'h1); failures++; end checks++;
        sw(A_MINSTRET, 64'h0, 2'b00);
        bus.instret_i = 1'b1;
        for (int i = 0; i < 3; i++) step();
        bus.instret_i = 1'b0;
        rd(A_MINSTRET);
        if (bus.csr_rdata_o !== 64'h3) begin $display("FAIL minstret_3 got=%h exp=%h", bus.csr_rdata_o, 64'h3); failures++; end checks++;
        bus.instret_i = 1'b1;
        sw(A_MINSTRET, 64'hA, 2'b00);
        bus.instret_i = 1'b0;
        if (bus.csr_rdata_o !== 64'hA) begin $display("FAIL minstret_wr got=%h exp=%h", bus.csr_rdata_o, 64'hA); failures++; end checks++;
        // Counters keep running through a trap cycle.
        bus.trap_i = 1'b1; bus.instret_i = 1'b1;
        bus.trap_pc_i = 64'h300; bus.trap_cause_i = 64'h2;
        step();
        bus.trap_i = 1'b0; bus.instret_i = 1'b0;
        if (bus.csr_rdata_o !== 64'hB) begin $display("FAIL minstret_trap got=%h exp=%h", bus.csr_rdata_o, 64'hB); failures++; end checks++;
    endtask

    task automatic test_reset_mid();
        sw(A_MSCRATCH, 64'h77, 2'b00);
        // Hold a write across a reset edge. It must be discarded.
        bus.csr_waddr_i = A_MSCRATCH; bus.csr_wdata_i = 64'h99; bus.csr_op_i = 2'b00; bus.csr_wen_i = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        if (bus.mstatus_o !== 64'h1800) begin $display("FAIL mid_mstatus got=%h exp=%h", bus.mstatus_o, 64'h1800); failures++; end checks++;
        rd(A_MTVEC);
        if (bus.csr_rdata_o !== 64'h8000_0000) begin $display("FAIL mid_mtvec got=%h exp=%h", bus.csr_rdata_o, 64'h8000_0000); failures++; end checks++;
        rd(A_MCYCLE);
        if (bus.csr_rdata_o !== 64'h0) begin $display("FAIL mid_mcycle got=%h exp=%h", bus.csr_rdata_o, 64'h0); failures++; end checks++;
        if (bus.mepc_o !== 64'h0) begin $display("FAIL mid_mepc got=%h exp=%h", bus.mepc_o, 64'h0); failures++; end checks++;
        step();
        rd(A_MSCRATCH);
        if (bus.csr_rdata_o !== 64'h0) begin $display("FAIL mid_wdrop got=%h exp=%h", bus.csr_rdata_o, 64'h0); failures++; end checks++;
        bus.csr_wen_i = 1'b0;
        rst = 1'b1;
        step();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        bus.csr_raddr_i = '0; bus.csr_wen_i = 1'b0; bus.csr_waddr_i = '0;
        bus.csr_wdata_i = '0; bus.csr_op_i = 2'b00; bus.trap_i = 1'b0;
        bus.trap_pc_i = '0; bus.trap_cause_i = '0; bus.mret_i = 1'b0;
        bus.instret_i = 1'b0; bus.timer_irq_i = 1'b0;
        test_reset();
        test_ops();
        test_trap();
        test_collision();
        test_irq();
        test_illegal();
        test_counters();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
